// File: rtl/lcd_page_arbiter.sv
// Shares the 16x2 LCD between the alarm, fare and info pages of the taximeter.
// Page switches and content refreshes land only on the driver's frame boundary.
module lcd_page_arbiter #(
    parameter int unsigned  DWELL_CYCLES = 100_000_000,
    parameter int unsigned  CNT_W        = 27,
    parameter logic [127:0] BLANK_ROW    = {16{8'h20}}
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic [2:0]   REQ,
    input  logic         FRAME_SYNC,
    input  logic [127:0] P0_ROW1,
    input  logic [127:0] P0_ROW2,
    input  logic [127:0] P1_ROW1,
    input  logic [127:0] P1_ROW2,
    input  logic [127:0] P2_ROW1,
    input  logic [127:0] P2_ROW2,
    output logic [127:0] row_1,
    output logic [127:0] row_2,
    output logic [2:0]   GRANT,
    output logic         PAGE_CHG
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_SHOW = 2'd2;

    localparam logic [2:0] PG_NONE  = 3'b000;
    localparam logic [2:0] PG_ALARM = 3'b001;
    localparam logic [2:0] PG_FARE  = 3'b010;
    localparam logic [2:0] PG_INFO  = 3'b100;

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 32'd1);

    logic [1:0]       state_q, state_d;
    logic [2:0]       pending_q, pending_d;
    logic [2:0]       grant_q, grant_d;
    logic [127:0]     row1_q, row1_d;
    logic [127:0]     row2_q, row2_d;
    logic             page_chg_q, page_chg_d;
    logic [CNT_W-1:0] dwell_q, dwell_d;
    logic             rr_last_q, rr_last_d;   // 0 = fare last granted, 1 = info

    logic [2:0]   winner_s;
    logic [2:0]   src_sel_s;
    logic [127:0] page_r1_s;
    logic [127:0] page_r2_s;
    logic         other_req_s;
    logic         switch_s;

    // Arbitration: alarm first, otherwise round-robin between fare and info
    always_comb begin
        winner_s = PG_NONE;
        if (REQ[0]) begin
            winner_s = PG_ALARM;
        end else if (rr_last_q == 1'b0) begin
            if (REQ[2])      winner_s = PG_INFO;
            else if (REQ[1]) winner_s = PG_FARE;
            else             winner_s = PG_NONE;
        end else begin
            if (REQ[1])      winner_s = PG_FARE;
            else if (REQ[2]) winner_s = PG_INFO;
            else             winner_s = PG_NONE;
        end
    end

    // Page content mux: SHOW refreshes the granted page, WAIT loads the pending one
    always_comb begin
        src_sel_s = (state_q == ST_SHOW) ? grant_q : pending_q;
        case (src_sel_s)
            PG_ALARM: begin page_r1_s = P0_ROW1;   page_r2_s = P0_ROW2;   end
            PG_FARE:  begin page_r1_s = P1_ROW1;   page_r2_s = P1_ROW2;   end
            PG_INFO:  begin page_r1_s = P2_ROW1;   page_r2_s = P2_ROW2;   end
            default:  begin page_r1_s = BLANK_ROW; page_r2_s = BLANK_ROW; end
        endcase
    end

    // Leave SHOW on request drop, alarm pre-emption, or expired dwell with a rival waiting
    always_comb begin
        if (grant_q[1])      other_req_s = REQ[2];
        else if (grant_q[2]) other_req_s = REQ[1];
        else                 other_req_s = 1'b0;
        switch_s = ((REQ & grant_q) == 3'b000)
                || (REQ[0] && !grant_q[0])
                || (!grant_q[0] && (dwell_q == DWELL_LAST) && other_req_s);
    end

    // Next-state logic for the page FSM and its datapath
    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        grant_d    = grant_q;
        row1_d     = row1_q;
        row2_d     = row2_q;
        page_chg_d = 1'b0;
        dwell_d    = dwell_q;
        rr_last_d  = rr_last_q;
        case (state_q)
            ST_IDLE: begin
                grant_d = PG_NONE;
                if (|REQ) begin
                    pending_d = winner_s;
                    state_d   = ST_WAIT;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (FRAME_SYNC) begin
                    row1_d  = page_r1_s;
                    row2_d  = page_r2_s;
                    grant_d = pending_q;
                    if (pending_q != grant_q) begin
                        page_chg_d = 1'b1;
                        dwell_d    = {CNT_W{1'b0}};
                    end else begin
                        page_chg_d = 1'b0;
                    end
                    if (pending_q == PG_FARE)      rr_last_d = 1'b0;
                    else if (pending_q == PG_INFO) rr_last_d = 1'b1;
                    else                           rr_last_d = rr_last_q;
                    state_d = (pending_q == PG_NONE) ? ST_IDLE : ST_SHOW;
                end else begin
                    pending_d = winner_s;
                end
            end
            ST_SHOW: begin
                if (FRAME_SYNC) begin
                    row1_d = page_r1_s;
                    row2_d = page_r2_s;
                end else begin
                    row1_d = row1_q;
                end
                if (dwell_q != DWELL_LAST) dwell_d = dwell_q + {{(CNT_W-1){1'b0}}, 1'b1};
                else                       dwell_d = dwell_q;
                if (switch_s) begin
                    pending_d = winner_s;
                    state_d   = ST_WAIT;
                end else begin
                    state_d   = ST_SHOW;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                pending_d = PG_NONE;
                grant_d   = PG_NONE;
                row1_d    = BLANK_ROW;
                row2_d    = BLANK_ROW;
                dwell_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            pending_q  <= PG_NONE;
            grant_q    <= PG_NONE;
            row1_q     <= BLANK_ROW;
            row2_q     <= BLANK_ROW;
            page_chg_q <= 1'b0;
            dwell_q    <= {CNT_W{1'b0}};
            rr_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            grant_q    <= grant_d;
            row1_q     <= row1_d;
            row2_q     <= row2_d;
            page_chg_q <= page_chg_d;
            dwell_q    <= dwell_d;
            rr_last_q  <= rr_last_d;
        end
    end

    assign row_1    = row1_q;
    assign row_2    = row2_q;
    assign GRANT    = grant_q;
    assign PAGE_CHG = page_chg_q;

endmodule

// File: tb/tb_lcd_page_arbiter.sv
// Directed bench for lcd_page_arbiter with a short dwell of 10 cycles.
module tb_lcd_page_arbiter;

    localparam logic [127:0] BLANK = {16{8'h20}};
    localparam logic [127:0] P0R1  = {16{8'h41}};
    localparam logic [127:0] P0R2  = {16{8'h42}};
    localparam logic [127:0] P1R1  = {16{8'h46}};
    localparam logic [127:0] P1R2  = {16{8'h47}};
    localparam logic [127:0] P2R1  = {16{8'h49}};
    localparam logic [127:0] P2R2  = {16{8'h4A}};
    localparam logic [127:0] P1NEW = {16{8'h31}};

    logic         CLK;
    logic         RST_N;
    logic [2:0]   REQ;
    logic         FRAME_SYNC;
    logic [127:0] P0_ROW1, P0_ROW2, P1_ROW1, P1_ROW2, P2_ROW1, P2_ROW2;
    logic [127:0] row_1, row_2;
    logic [2:0]   GRANT;
    logic         PAGE_CHG;

    int n_cmp;
    int n_err;

    lcd_page_arbiter #(.DWELL_CYCLES(10), .CNT_W(4)) dut (
        .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .FRAME_SYNC(FRAME_SYNC),
        .P0_ROW1(P0_ROW1), .P0_ROW2(P0_ROW2),
        .P1_ROW1(P1_ROW1), .P1_ROW2(P1_ROW2),
        .P2_ROW1(P2_ROW1), .P2_ROW2(P2_ROW2),
        .row_1(row_1), .row_2(row_2), .GRANT(GRANT), .PAGE_CHG(PAGE_CHG)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic sync();
        FRAME_SYNC = 1'b1;
        tick();
        FRAME_SYNC = 1'b0;
    endtask

    task automatic tick3();
        tick(); tick(); tick();
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        P0_ROW1 = P0R1; P0_ROW2 = P0R2;
        P1_ROW1 = P1R1; P1_ROW2 = P1R2;
        P2_ROW1 = P2R1; P2_ROW2 = P2R2;
        REQ = 3'b000; FRAME_SYNC = 1'b0; RST_N = 1'b0;
        tick(); tick();
        chk("rst_row1", row_1, BLANK);
        chk("rst_row2", row_2, BLANK);
        chk("rst_grant", {125'd0, GRANT}, 128'd0);
        chk("rst_pchg", {127'd0, PAGE_CHG}, 128'd0);
        RST_N = 1'b1;
        tick();

        // First grant: fare, only at the frame boundary
        REQ = 3'b010;
        tick3();
        chk("pre_sync_row1", row_1, BLANK);
        chk("pre_sync_grant", {125'd0, GRANT}, 128'd0);
        sync();
        chk("fare_grant", {125'd0, GRANT}, {125'd0, 3'b010});
        chk("fare_row1", row_1, P1R1);
        chk("fare_row2", row_2, P1R2);
        chk("fare_pchg", {127'd0, PAGE_CHG}, {127'd0, 1'b1});
        tick();
        chk("fare_pchg_pulse", {127'd0, PAGE_CHG}, 128'd0);

        // Live content refresh
        P1_ROW1 = P1NEW;
        tick();
        chk("refresh_hold", row_1, P1R1);
        sync();
        chk("refresh_row1", row_1, P1NEW);
        chk("refresh_pchg", {127'd0, PAGE_CHG}, 128'd0);

        // Alarm pre-emption at dwell 3, then held with no rotation
        REQ = 3'b011;
        tick(); tick();
        chk("alarm_wait_grant", {125'd0, GRANT}, {125'd0, 3'b010});
        sync();
        chk("alarm_grant", {125'd0, GRANT}, {125'd0, 3'b001});
        chk("alarm_row1", row_1, P0R1);
        chk("alarm_pchg", {127'd0, PAGE_CHG}, {127'd0, 1'b1});
        repeat (12) begin
            tick3();
            sync();
        end
        chk("alarm_hold_grant", {125'd0, GRANT}, {125'd0, 3'b001});
        chk("alarm_hold_row2", row_2, P0R2);
        chk("alarm_hold_pchg", {127'd0, PAGE_CHG}, 128'd0);

        REQ = 3'b010;
        tick(); tick();
        sync();
        chk("back_fare_grant", {125'd0, GRANT}, {125'd0, 3'b010});
        chk("back_fare_pchg", {127'd0, PAGE_CHG}, {127'd0, 1'b1});

        // Round-robin with dwell 10 and sync every 4 cycles
        REQ = 3'b110;
        tick3(); sync();
        tick3(); sync();
        chk("rr_fare_dwell", {125'd0, GRANT}, {125'd0, 3'b010});
        tick3(); sync();
        chk("rr_info_grant", {125'd0, GRANT}, {125'd0, 3'b100});
        chk("rr_info_row1", row_1, P2R1);
        chk("rr_info_pchg", {127'd0, PAGE_CHG}, {127'd0, 1'b1});
        tick3(); sync();
        tick3(); sync();
        chk("rr_info_dwell", {125'd0, GRANT}, {125'd0, 3'b100});
        tick3(); sync();
        chk("rr_fare2_grant", {125'd0, GRANT}, {125'd0, 3'b010});
        chk("rr_fare2_row1", row_1, P1NEW);

        // Rotation decision coinciding with a sync applies one sync later
        repeat (9) tick();
        sync();
        chk("coinc_grant", {125'd0, GRANT}, {125'd0, 3'b010});
        chk("coinc_pchg", {127'd0, PAGE_CHG}, 128'd0);
        tick3();
        sync();
        chk("coinc_after_grant", {125'd0, GRANT}, {125'd0, 3'b100});
        chk("coinc_after_pchg", {127'd0, PAGE_CHG}, {127'd0, 1'b1});

        // Drop every request on a sync edge, then blank on the following sync
        REQ = 3'b000;
        sync();
        chk("drop_coinc_grant", {125'd0, GRANT}, {125'd0, 3'b100});
        chk("drop_coinc_row1", row_1, P2R1);
        tick();
        sync();
        chk("blank_row1", row_1, BLANK);
        chk("blank_row2", row_2, BLANK);
        chk("blank_grant", {125'd0, GRANT}, 128'd0);
        chk("blank_pchg", {127'd0, PAGE_CHG}, {127'd0, 1'b1});

        // Asynchronous reset while waiting with FRAME_SYNC high
        REQ = 3'b100;
        tick();
        sync();
        chk("pre_rst_grant", {125'd0, GRANT}, {125'd0, 3'b100});
        REQ = 3'b010;
        tick();
        FRAME_SYNC = 1'b1;
        #2;
        RST_N = 1'b0;
        #1;
        chk("arst_row1", row_1, BLANK);
        chk("arst_row2", row_2, BLANK);
        chk("arst_grant", {125'd0, GRANT}, 128'd0);
        chk("arst_pchg", {127'd0, PAGE_CHG}, 128'd0);
        tick();
        chk("arst_hold_grant", {125'd0, GRANT}, 128'd0);
        FRAME_SYNC = 1'b0;
        RST_N = 1'b1;
        tick();
        chk("post_rst_grant", {125'd0, GRANT}, 128'd0);
        sync();
        chk("post_rst_fare", {125'd0, GRANT}, {125'd0, 3'b010});
        chk("post_rst_pchg", {127'd0, PAGE_CHG}, {127'd0, 1'b1});
        chk("post_rst_row1", row_1, P1NEW);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
